lockstep_miter: RTL and testbench
=================================

LOCKSTEP_MITER -- requirements
Module: lockstep_miter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning compared data width per channel.
REQ-002 The block SHALL have parameter CHANNELS, default 1, meaning number of independent compared channels (1..16).
REQ-003 The block SHALL have parameter SKEW, default 0, meaning cycles the reference stream is delayed before comparison (0..7).
REQ-004 The block SHALL have parameter SETTLE, default 2, meaning cycles after reset release before comparison is armed (1..255).
REQ-005 The block SHALL have parameter CNT_W, default 16, meaning mismatch counter width.
REQ-006 The block SHALL have port i_clk, input, 1, the single clock; all state is on its rising edge.
REQ-007 The block SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have port i_valid_ref, input, CHANNELS, per-channel reference valid.
REQ-009 The block SHALL have port i_data_ref, input, CHANNELS*WIDTH, reference data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 The block SHALL have port i_valid_uut, input, CHANNELS, per-channel mutant/UUT valid.
REQ-011 The block SHALL have port i_data_uut, input, CHANNELS*WIDTH, UUT data, same packing.
REQ-012 The block SHALL have port i_clear, input, 1, synchronous clear of sticky status and counter.
REQ-013 The block SHALL have outputs o_armed (1), o_mismatch (1, sticky), o_mismatch_pulse (1), o_first_chan ($clog2(CHANNELS) min 1), o_first_ref (WIDTH), o_first_uut (WIDTH), o_err_count (CNT_W).

Function
REQ-014 Reference valid and data SHALL pass through a SKEW-stage register chain; SKEW=0 means combinational pass-through; UUT inputs are never delayed.
REQ-015 Channel k SHALL mismatch when armed and (delayed ref valid != UUT valid, or both valid and data differ); data is ignored when both valids are low.
REQ-016 The state machine SHALL have states SETTLING, ARMED, TRIPPED; reset enters SETTLING.
REQ-017 SETTLING SHALL count SETTLE cycles after reset release, then enter ARMED; o_armed is 1 in ARMED and TRIPPED only.
REQ-018 ARMED SHALL move to TRIPPED on the first cycle any channel mismatches, registering o_first_chan (lowest-index mismatching channel), o_first_ref and o_first_uut (that channel's delayed ref and UUT data) on that edge.
REQ-019 In TRIPPED, first-mismatch captures SHALL hold; further mismatches only increment the counter.
REQ-020 o_mismatch_pulse SHALL be 1 for exactly the cycle after each mismatching cycle (registered, one-cycle latency); o_mismatch is 1 in TRIPPED.
REQ-021 o_err_count SHALL increment by 1 per mismatching cycle regardless of channel count, saturating at all-ones.
REQ-022 i_clear SHALL return TRIPPED to ARMED and zero counter and captures; if a mismatch occurs in the same cycle, it SHALL be recorded as a fresh first mismatch (state TRIPPED, count 1).
REQ-023 i_clear during SETTLING SHALL be ignored.

Reset
REQ-024 On i_reset_n low, all outputs SHALL be 0 and the skew chain cleared, immediately and asynchronously; reset mid-operation discards captures and restarts SETTLING.

Configuration
REQ-025 With macro MITER_CYCLE_STAMP_EN defined, the block SHALL add output o_cycle_stamp (32), a saturating cycle counter from reset release captured at the first mismatch (reset 0, cleared by i_clear); without it the port and counter SHALL not exist.

Verification
REQ-026 SETTLE=2, identical streams 0x00..0xFF for 256 cycles -> o_mismatch=0, o_err_count=0, o_armed=1 from cycle 2.
REQ-027 CHANNELS=2, channel 1 UUT data 0x5A vs ref 0xA5 at cycle 10 -> o_mismatch_pulse at cycle 11, o_first_chan=1, o_first_ref=0xA5, o_first_uut=0x5A, count 1.
REQ-028 SKEW=3, UUT equals ref delayed 3 cycles -> no mismatch; SKEW=2 with same stimulus -> trip on first valid beat.
REQ-029 CNT_W=4, 20 consecutive mismatching cycles -> o_err_count=0xF; i_clear -> count 0, o_mismatch 0.
REQ-030 Mismatch during SETTLING then reset asserted mid-TRIPPED -> no trip while settling; all outputs 0 asynchronously, re-arm SETTLE cycles after release.
REQ-031 MITER_CYCLE_STAMP_EN defined, first mismatch at cycle 37 after reset release -> o_cycle_stamp=37.

Source files
------------

// File: rtl/lockstep_miter.sv
// lockstep_miter: compares a (skew-delayed) reference stream against a UUT stream per channel and records the first divergence.
// Optional MITER_CYCLE_STAMP_EN adds o_cycle_stamp, the cycle count at which the first mismatch was captured.
module lockstep_miter #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 1,
    parameter int SKEW     = 0,
    parameter int SETTLE   = 2,
    parameter int CNT_W    = 16,
    localparam int CW      = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic [CHANNELS-1:0]       i_valid_ref,
    input  logic [CHANNELS*WIDTH-1:0] i_data_ref,
    input  logic [CHANNELS-1:0]       i_valid_uut,
    input  logic [CHANNELS*WIDTH-1:0] i_data_uut,
    input  logic                      i_clear,
    output logic                      o_armed,
    output logic                      o_mismatch,
    output logic                      o_mismatch_pulse,
    output logic [CW-1:0]             o_first_chan,
    output logic [WIDTH-1:0]          o_first_ref,
    output logic [WIDTH-1:0]          o_first_uut,
    output logic [CNT_W-1:0]          o_err_count
`ifdef MITER_CYCLE_STAMP_EN
    ,
    output logic [31:0]               o_cycle_stamp
`endif
);
    typedef enum logic [1:0] {SETTLING, ARMED, TRIPPED} state_t;
    state_t state, next_state;
    logic [7:0] settle_cnt;
    logic [CHANNELS-1:0] vref, mm;
    logic [CHANNELS*WIDTH-1:0] dref;
    logic hit, capture, wipe;
    logic [CW-1:0] fc;
    logic [WIDTH-1:0] fr, fu;

    generate
        if (SKEW == 0) begin : g_pass
            assign vref = i_valid_ref;
            assign dref = i_data_ref;
        end else begin : g_skew
            logic [CHANNELS-1:0]       vq [SKEW];
            logic [CHANNELS*WIDTH-1:0] dq [SKEW];
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    for (int i = 0; i < SKEW; i++) begin
                        vq[i] <= '0;
                        dq[i] <= '0;
                    end
                end else begin
                    vq[0] <= i_valid_ref;
                    dq[0] <= i_data_ref;
                    for (int i = 1; i < SKEW; i++) begin
                        vq[i] <= vq[i-1];
                        dq[i] <= dq[i-1];
                    end
                end
            end
            assign vref = vq[SKEW-1];
            assign dref = dq[SKEW-1];
        end
    endgenerate

    // Descending scan so the lowest-index mismatching channel wins.
    always_comb begin
        mm = '0;
        fc = '0;
        fr = '0;
        fu = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            mm[k] = (vref[k] != i_valid_uut[k]) ||
                    (vref[k] && i_valid_uut[k] &&
                     dref[k*WIDTH +: WIDTH] != i_data_uut[k*WIDTH +: WIDTH]);
            if (mm[k]) begin
                fc = CW'(k);
                fr = dref[k*WIDTH +: WIDTH];
                fu = i_data_uut[k*WIDTH +: WIDTH];
            end
        end
    end

    assign hit     = (state != SETTLING) && (|mm);
    assign wipe    = i_clear && (state != SETTLING);
    assign capture = hit && (state == ARMED || i_clear);

    always_comb begin
        next_state = state;
        case (state)
            SETTLING: next_state = (settle_cnt == 8'(SETTLE - 1)) ? ARMED : SETTLING;
            ARMED:    next_state = hit ? TRIPPED : ARMED;
            TRIPPED:  next_state = (i_clear && !hit) ? ARMED : TRIPPED;
            default:  next_state = SETTLING;
        endcase
    end

    assign o_armed    = state != SETTLING;
    assign o_mismatch = state == TRIPPED;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state            <= SETTLING;
            settle_cnt       <= '0;
            o_mismatch_pulse <= 1'b0;
            o_err_count      <= '0;
            o_first_chan     <= '0;
            o_first_ref      <= '0;
            o_first_uut      <= '0;
        end else begin
            state            <= next_state;
            settle_cnt       <= (state == SETTLING) ? settle_cnt + 8'd1 : settle_cnt;
            o_mismatch_pulse <= hit;
            if (wipe)
                o_err_count <= hit ? CNT_W'(1) : '0;
            else if (hit && o_err_count != '1)
                o_err_count <= o_err_count + CNT_W'(1);
            if (capture) begin
                o_first_chan <= fc;
                o_first_ref  <= fr;
                o_first_uut  <= fu;
            end else if (wipe) begin
                o_first_chan <= '0;
                o_first_ref  <= '0;
                o_first_uut  <= '0;
            end
        end
    end

`ifdef MITER_CYCLE_STAMP_EN
    logic [31:0] cyc;
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cyc           <= '0;
            o_cycle_stamp <= '0;
        end else begin
            cyc           <= (cyc != '1) ? cyc + 32'd1 : cyc;
            o_cycle_stamp <= capture ? cyc : wipe ? '0 : o_cycle_stamp;
        end
    end
`endif
endmodule

// File: tb/tb_lockstep_miter.sv
// tb_lockstep_miter: directed checks of lockstep_miter (2-channel unskewed instance plus SKEW=3/SKEW=2 single-channel instances).
module tb_lockstep_miter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    int checks = 0;
    int failures = 0;

    logic [1:0]  a_vr = '0, a_vu = '0;
    logic [15:0] a_dr = '0, a_du = '0;
    logic        a_armed, a_mm, a_pulse, a_fc;
    logic [7:0]  a_fr, a_fu;
    logic [3:0]  a_cnt;

    logic        b_vr = 1'b0, b_vu = 1'b0;
    logic [7:0]  b_dr = '0, b_du = '0;
    logic        b_armed, b_mm, b_pulse, b_fc, c_armed, c_mm, c_pulse, c_fc;
    logic [7:0]  b_fr, b_fu, c_fr, c_fu;
    logic [15:0] b_cnt, c_cnt;
`ifdef MITER_CYCLE_STAMP_EN
    logic [31:0] a_stamp, b_stamp, c_stamp;
`endif

    always #5 clk = ~clk;

    lockstep_miter #(.WIDTH(8), .CHANNELS(2), .SKEW(0), .SETTLE(2), .CNT_W(4)) u_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid_ref(a_vr), .i_data_ref(a_dr),
        .i_valid_uut(a_vu), .i_data_uut(a_du), .i_clear(clr),
        .o_armed(a_armed), .o_mismatch(a_mm), .o_mismatch_pulse(a_pulse),
        .o_first_chan(a_fc), .o_first_ref(a_fr), .o_first_uut(a_fu), .o_err_count(a_cnt)
`ifdef MITER_CYCLE_STAMP_EN
        , .o_cycle_stamp(a_stamp)
`endif
    );

    lockstep_miter #(.SKEW(3)) u_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid_ref(b_vr), .i_data_ref(b_dr),
        .i_valid_uut(b_vu), .i_data_uut(b_du), .i_clear(1'b0),
        .o_armed(b_armed), .o_mismatch(b_mm), .o_mismatch_pulse(b_pulse),
        .o_first_chan(b_fc), .o_first_ref(b_fr), .o_first_uut(b_fu), .o_err_count(b_cnt)
`ifdef MITER_CYCLE_STAMP_EN
        , .o_cycle_stamp(b_stamp)
`endif
    );

    lockstep_miter #(.SKEW(2)) u_c (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid_ref(b_vr), .i_data_ref(b_dr),
        .i_valid_uut(b_vu), .i_data_uut(b_du), .i_clear(1'b0),
        .o_armed(c_armed), .o_mismatch(c_mm), .o_mismatch_pulse(c_pulse),
        .o_first_chan(c_fc), .o_first_ref(c_fr), .o_first_uut(c_fu), .o_err_count(c_cnt)
`ifdef MITER_CYCLE_STAMP_EN
        , .o_cycle_stamp(c_stamp)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_armed", a_armed, 0);
        chk("rst_mm", a_mm, 0);
        chk("rst_pulse", a_pulse, 0);
        chk("rst_cnt", a_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // mismatching stimulus while settling must not trip
        a_vr = 2'b01; a_vu = 2'b01; a_dr = 16'h0011; a_du = 16'h0022;
        step();
        chk("settle0_armed", a_armed, 0);
        chk("settle0_pulse", a_pulse, 0);
        step();
        chk("settle1_armed", a_armed, 1);
        chk("settle1_mm", a_mm, 0);
        chk("settle1_pulse", a_pulse, 0);
        chk("settle1_cnt", a_cnt, 0);
        for (int i = 0; i < 256; i++) begin
            a_vr = 2'b11; a_vu = 2'b11;
            a_dr = {~8'(i), 8'(i)};
            a_du = a_dr;
            b_vr = 1'b1; b_dr = 8'(i + 1);
            b_vu = (i >= 3);
            b_du = (i >= 3) ? 8'(i - 2) : 8'h00;
            step();
        end
        chk("ident_mm", a_mm, 0);
        chk("ident_cnt", a_cnt, 0);
        chk("ident_pulse", a_pulse, 0);
        chk("ident_armed", a_armed, 1);
        chk("skew3_mm", b_mm, 0);
        chk("skew3_cnt", b_cnt, 0);
        chk("skew2_mm", c_mm, 1);
        chk("skew2_fref", c_fr, 8'h01);
        chk("skew2_fuut", c_fu, 8'h00);
        a_vr = 2'b00; a_vu = 2'b00; a_dr = 16'h1234; a_du = 16'h4321;
        step();
        chk("vlow_pulse", a_pulse, 0);
        chk("vlow_mm", a_mm, 0);
        a_vr = 2'b11; a_vu = 2'b11; a_dr = 16'hA507; a_du = 16'h5A07;
        step();
        chk("ch1_pulse", a_pulse, 1);
        chk("ch1_mm", a_mm, 1);
        chk("ch1_fchan", a_fc, 1);
        chk("ch1_fref", a_fr, 8'hA5);
        chk("ch1_fuut", a_fu, 8'h5A);
        chk("ch1_cnt", a_cnt, 1);
        a_dr = 16'h0101; a_du = 16'h0101;
        step();
        chk("after_pulse", a_pulse, 0);
        chk("after_mm", a_mm, 1);
        chk("after_cnt", a_cnt, 1);
        a_dr = 16'h0102; a_du = 16'h0304;
        step();
        chk("hold_fchan", a_fc, 1);
        chk("hold_fref", a_fr, 8'hA5);
        chk("hold_cnt", a_cnt, 2);
        a_dr = 16'h0505; a_du = 16'h0505; a_vr = 2'b01; a_vu = 2'b00;
        step();
        chk("vmis_cnt", a_cnt, 3);
        a_vr = 2'b11; a_vu = 2'b11; a_dr = 16'h0000; a_du = 16'h00FF;
        repeat (20) step();
        chk("sat_cnt", a_cnt, 4'hF);
        a_du = a_dr; clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_cnt", a_cnt, 0);
        chk("clr_mm", a_mm, 0);
        chk("clr_armed", a_armed, 1);
        chk("clr_fref", a_fr, 0);
        a_dr = 16'hA500; a_du = 16'h5A00;
        step();
        chk("retrip_mm", a_mm, 1);
        clr = 1'b1; a_dr = 16'h0033; a_du = 16'h0044;
        step();
        clr = 1'b0;
        chk("clrhit_mm", a_mm, 1);
        chk("clrhit_cnt", a_cnt, 1);
        chk("clrhit_fchan", a_fc, 0);
        chk("clrhit_fref", a_fr, 8'h33);
        chk("clrhit_fuut", a_fu, 8'h44);
        clr = 1'b1; a_du = a_dr;
        step();
        clr = 1'b0; a_dr = 16'h3010; a_du = 16'h4020;
        step();
        chk("low_fchan", a_fc, 0);
        chk("low_fref", a_fr, 8'h10);
        chk("low_fuut", a_fu, 8'h20);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_armed", a_armed, 0);
        chk("arst_mm", a_mm, 0);
        chk("arst_pulse", a_pulse, 0);
        chk("arst_cnt", a_cnt, 0);
        chk("arst_fref", a_fr, 0);
        chk("arst_fuut", a_fu, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; a_du = a_dr;
        step();
        chk("rearm0", a_armed, 0);
        step();
        chk("rearm1", a_armed, 1);
        chk("rearm_mm", a_mm, 0);
`ifdef MITER_CYCLE_STAMP_EN
        repeat (35) step();
        a_du = 16'h0000;
        step();
        chk("stamp", a_stamp, 37);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
